// File: rtl/radix_stream_ntt_engine.sv
// Streaming NTT/INTT engine: loads one frame of 2^L coefficients, transforms it in place
// on a single modular multiplier, then streams the result out in buffer order.
module radix_stream_ntt_engine #(
   parameter int WIDTH    = 18,
   parameter int PRIME    = 65537,
   parameter int MAX_LOG2 = 3
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [1:0]                      radix_mode,
   input  logic                            mode,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   input  logic [(MAX_LOG2+1)*WIDTH-1:0]   weight_stream,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic                            out_last,
   output logic                            busy
);
   localparam int DEPTH = 1 << MAX_LOG2;
   localparam int AW    = MAX_LOG2;
   localparam int SW    = $clog2(MAX_LOG2 + 1);
   localparam logic [WIDTH-1:0]   P_W    = WIDTH'(PRIME);
   localparam logic [2*WIDTH-1:0] P_WIDE = (2*WIDTH)'(PRIME);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

   function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P_W}) s = s - {1'b0, P_W};
      return WIDTH'(s);
   endfunction

   // Wrap-around in WIDTH bits makes a - b + P exact whenever a < b.
   function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (a >= b) ? (a - b) : (a - b + P_W);
   endfunction

   function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      return WIDTH'(p % P_WIDE);
   endfunction

   state_t state, state_next;
   logic [AW-1:0] cnt;
   logic [SW-1:0] stage, log_n, l_cfg;
   logic          pass, inv;

   logic [WIDTH-1:0]                  x_buf [DEPTH];
   logic [(MAX_LOG2+1)*WIDTH-1:0]     w_buf [DEPTH];

   logic [AW-1:0] last_idx, half_last, h_idx, j_idx, jh_idx, wr_idx;
   logic [WIDTH-1:0] u_val, v_val, diff, mul_a, w_sel, prod;
   logic [(MAX_LOG2+1)*WIDTH-1:0] w_word;
   logic compute_done;

   always_comb begin
      if (int'(radix_mode) > MAX_LOG2 - 1) l_cfg = SW'(MAX_LOG2);
      else                                 l_cfg = SW'(radix_mode) + 1'b1;
   end

   // Butterfly pair for counter value cnt in the current stage: insert a zero at bit (stage-1).
   always_comb begin
      last_idx  = (AW'(1) << log_n) - AW'(1);
      half_last = (AW'(1) << (log_n - 1'b1)) - AW'(1);
      h_idx     = AW'(1) << (stage - 1'b1);
      j_idx     = ((cnt >> (stage - 1'b1)) << stage) | (cnt & (h_idx - AW'(1)));
      jh_idx    = j_idx | h_idx;
      wr_idx    = (state == IDLE) ? '0 : cnt;
      u_val     = x_buf[j_idx];
      v_val     = x_buf[jh_idx];
      diff      = mod_sub(u_val, v_val);
      w_word    = w_buf[pass ? cnt : j_idx];
      w_sel     = pass ? w_word[WIDTH-1:0] : w_word[int'(stage)*WIDTH +: WIDTH];
      mul_a     = pass ? x_buf[cnt] : (inv ? diff : v_val);
      prod      = mod_mul(mul_a, w_sel);
      compute_done = pass ? (inv && cnt == last_idx)
                          : (!inv && cnt == half_last && stage == log_n);
   end

   assign in_ready = (state == IDLE) || (state == LOAD);
   assign busy     = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = LOAD;
         LOAD:    if (in_valid && cnt == last_idx) state_next = COMPUTE;
         COMPUTE: if (compute_done) state_next = DRAIN;
         DRAIN:   if (out_valid && out_ready && out_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         stage     <= '0;
         log_n     <= SW'(1);
         pass      <= 1'b0;
         inv       <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               log_n <= l_cfg;
               inv   <= mode;
               cnt   <= AW'(1);
            end
            LOAD: if (in_valid) begin
               if (cnt == last_idx) begin
                  cnt   <= '0;
                  pass  <= !inv;
                  stage <= inv ? log_n : SW'(1);
               end else cnt <= cnt + 1'b1;
            end
            // NTT: pre-multiply pass then stages 1..L; INTT: stages L..1 then post-multiply pass.
            COMPUTE: if (pass) begin
               if (cnt == last_idx) begin
                  cnt <= '0;
                  if (!inv) begin
                     pass  <= 1'b0;
                     stage <= SW'(1);
                  end
               end else cnt <= cnt + 1'b1;
            end else begin
               if (cnt == half_last) begin
                  cnt <= '0;
                  if (!inv) begin
                     if (stage != log_n) stage <= stage + 1'b1;
                  end else if (stage == SW'(1)) pass <= 1'b1;
                  else stage <= stage - 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            DRAIN: if (!out_valid || out_ready) begin
               if (out_valid && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  cnt       <= '0;
               end else begin
                  out_valid <= 1'b1;
                  out_data  <= x_buf[cnt];
                  out_last  <= (cnt == last_idx);
                  cnt       <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (in_ready && in_valid) begin
         x_buf[wr_idx] <= in_data;
         w_buf[wr_idx] <= weight_stream;
      end else if (state == COMPUTE) begin
         if (pass) x_buf[cnt] <= prod;
         else begin
            x_buf[j_idx]  <= inv ? mod_add(u_val, v_val) : mod_add(u_val, prod);
            x_buf[jh_idx] <= inv ? prod : mod_sub(u_val, prod);
         end
      end
   end
endmodule
